datamem_pack: RTL and testbench
===============================

DATAMEM_PACK -- requirements
Module: datamem_pack

Interface
REQ-001 Parameter: depth, default 6, address width of the downstream 64-bit data memory (2^depth entries).
REQ-002 sys_clk  input  1  sole clock; all state updates on rising edge.
REQ-003 sys_rst  input  1  reset, asynchronous, active-high.
REQ-004 in_data  input  32  inbound dword from link layer; first dword of a pair is the low half.
REQ-005 in_valid  input  1  in_data valid.
REQ-006 in_last  input  1  qualifies in_data as final dword of frame.
REQ-007 in_ready  output  1  block accepts dword this cycle; transfer = in_valid & in_ready.
REQ-008 rd_done  input  1  consumer has drained one 64-bit entry (one pulse per entry).
REQ-009 mem_a  output  depth  write address to data memory.
REQ-010 mem_we  output  8  byte write enables; bit i covers mem_di[8i+7:8i].
REQ-011 mem_di  output  64  write data.
REQ-012 level  output  depth+1  committed entries not yet drained, 0..2^depth.
REQ-013 frame_done  output  1  one-cycle pulse with the write carrying the frame's last dword.

Function
REQ-014 States: LOW (no dword held) and HIGH (low dword held in hold register).
REQ-015 LOW + transfer, in_last=0: capture in_data in hold register; go HIGH; no write.
REQ-016 LOW + transfer, in_last=1: next cycle mem_we=8'h0F, mem_di={32'h0,in_data}; stay LOW.
REQ-017 HIGH + transfer (any in_last): next cycle mem_we=8'hFF, mem_di={in_data,hold}; go LOW.
REQ-018 Write outputs registered: exactly one cycle from accepting transfer to mem_we assertion; mem_we=8'h00 in all other cycles.
REQ-019 Write pointer starts at 0; advances by 1 after each write; wraps 2^depth-1 -> 0; mem_a = pointer value of current write.
REQ-020 level +1 on each write cycle, -1 on rd_done; both same cycle -> unchanged.
REQ-021 rd_done with level=0 ignored; level never underflows.
REQ-022 in_ready = (level + write-in-flight) < 2^depth, combinational from registers only; never depends on in_valid.
REQ-023 level never exceeds 2^depth; no write issued when memory is full.
REQ-024 frame_done asserted in the same cycle as the write produced by the in_last transfer.
REQ-025 Transfer with in_valid=0 has no effect regardless of in_data/in_last.

Reset
REQ-026 On sys_rst: state LOW, pointer 0, level 0, hold 0, mem_we 8'h00, mem_di 0, mem_a 0, frame_done 0; in_ready 1 after release.
REQ-027 Reset mid-frame discards held dword and pending write; no partial write after release.

Structure
REQ-028 Shared package datamem_pkg holds the state encoding (LOW/HIGH) and byte-enable constants WE_FULL=8'hFF, WE_LOW=8'h0F.
REQ-029 No sub-module; instantiated beside datamem at the port level, driving its a/we/di directly, with read side issuing rd_done.

Verification
REQ-030 Dwords 0x11111111,0x22222222 (last) -> one write, a=0, we=FF, di=0x2222222211111111, frame_done=1, level=1.
REQ-031 Single dword 0xDEADBEEF with in_last -> a=0, we=0F, di=0x00000000DEADBEEF, state LOW.
REQ-032 depth=6, 128 dwords, no rd_done -> 64 writes a=0..63, level=64, in_ready=0; one rd_done -> level=63, in_ready=1.
REQ-033 Keep level ~32, stream 200 dwords with concurrent rd_done -> mem_a wraps 63->0, level consistent, no write when level=64.
REQ-034 Assert sys_rst after one low dword accepted -> no write afterward, level=0, next pair lands at a=0.
REQ-035 rd_done while level=0 -> level stays 0, no spurious write.

Source files
------------

// File: rtl/datamem_pkg.sv
// Shared definitions for the dword-to-qword packer and the data memory it feeds.
package datamem_pkg;

    // Packer state: LOW = no dword held, HIGH = low dword waiting in the hold register.
    typedef enum logic {
        LOW  = 1'b0,
        HIGH = 1'b1
    } state_t;

    // Byte-enable patterns presented on the memory write port.
    localparam logic [7:0] WE_FULL = 8'hFF;
    localparam logic [7:0] WE_LOW  = 8'h0F;
    localparam logic [7:0] WE_NONE = 8'h00;

endpackage

// File: rtl/datamem_pack_if.sv
// Inbound link-layer stream, consumer drain strobe and 64-bit memory write port.
interface datamem_pack_if #(
    parameter int depth = 6
);
    logic [31:0]      in_data;
    logic             in_valid;
    logic             in_last;
    logic             in_ready;
    logic             rd_done;
    logic [depth-1:0] mem_a;
    logic [7:0]       mem_we;
    logic [63:0]      mem_di;
    logic [depth:0]   level;
    logic             frame_done;

    // Link layer and read side: supplies dwords and drain pulses, observes the write port.
    modport master (
        output in_data, in_valid, in_last, rd_done,
        input  in_ready, mem_a, mem_we, mem_di, level, frame_done
    );

    // Packer: accepts dwords and drains, drives the memory write port.
    modport slave (
        input  in_data, in_valid, in_last, rd_done,
        output in_ready, mem_a, mem_we, mem_di, level, frame_done
    );
endinterface

// File: rtl/datamem_pack.sv
// Packs pairs of inbound 32-bit dwords into 64-bit writes to a 2^depth-entry data
// memory, tracks how many written entries the consumer has not yet drained, and
// back-pressures the link layer when the memory would overflow.
module datamem_pack
    import datamem_pkg::*;
#(
    parameter int depth = 6
) (
    input  logic           sys_clk,
    input  logic           sys_rst,
    datamem_pack_if.slave  bus
);

    // Occupancy value at which the memory is full (2^depth), one bit wider than level.
    localparam logic [depth+1:0] FULL_COUNT = {2'b01, {depth{1'b0}}};

    state_t           state_q, state_d;
    logic [31:0]      hold_q;
    logic [depth-1:0] ptr_q;
    logic [depth:0]   level_q;
    logic [7:0]       we_q, we_d;
    logic [63:0]      di_q, di_d;
    logic             fd_q, fd_d;

    logic             xfer;
    logic             wr_busy;
    logic             drain;
    logic [depth+1:0] occupancy;

    // A write is in flight whenever the registered write port is active; it is not
    // yet counted in level, so it must be added before deciding whether there is room.
    assign wr_busy   = (we_q != WE_NONE);
    assign occupancy = {1'b0, level_q} + (depth+2)'(wr_busy);
    assign bus.in_ready = (occupancy < FULL_COUNT);
    assign xfer      = bus.in_valid & bus.in_ready;
    // A drain pulse against an empty memory has nothing to remove.
    assign drain     = bus.rd_done & (level_q != '0);

    // State register.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values, independent of process evaluation order.
        if (sys_rst) state_q <= LOW;
        else         state_q <= state_d;
    end

    // Next-state: a non-final dword in LOW is held; any transfer in HIGH completes the pair.
    always_comb begin
        // NOTE: defaulting every combinational output first guarantees no path
        // leaves it unassigned, so no latch is inferred.
        state_d = state_q;
        if (xfer) begin
            unique case (state_q)
                LOW:     if (!bus.in_last) state_d = HIGH;
                HIGH:    state_d = LOW;
                default: state_d = LOW;
            endcase
        end
    end

    // Write decode: which bytes, what data and whether this write closes a frame.
    always_comb begin
        we_d = WE_NONE;
        di_d = 64'h0;
        fd_d = 1'b0;
        if (xfer) begin
            unique case (state_q)
                LOW: begin
                    if (bus.in_last) begin
                        we_d = WE_LOW;
                        di_d = {32'h0, bus.in_data};
                        fd_d = 1'b1;
                    end
                end
                HIGH: begin
                    we_d = WE_FULL;
                    di_d = {bus.in_data, hold_q};
                    fd_d = bus.in_last;
                end
                default: begin
                    we_d = WE_NONE;
                end
            endcase
        end
    end

    // Hold register and registered write port, one cycle behind the accepting transfer.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        // NOTE: data registers are reset too so the memory port shows a known
        // value right after reset and a held half-pair cannot leak into a later write.
        if (sys_rst) begin
            hold_q <= 32'h0;
            we_q   <= WE_NONE;
            di_q   <= 64'h0;
            fd_q   <= 1'b0;
        end else begin
            if (xfer && (state_q == LOW) && !bus.in_last) hold_q <= bus.in_data;
            we_q <= we_d;
            di_q <= di_d;
            fd_q <= fd_d;
        end
    end

    // Write pointer: addresses the current write, then steps on, wrapping at 2^depth.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst)      ptr_q <= '0;
        else if (wr_busy) ptr_q <= ptr_q + depth'(1);
    end

    // Committed-but-undrained entry count; a write and a drain together cancel.
    always_ff @(posedge sys_clk or posedge sys_rst) begin
        if (sys_rst) begin
            level_q <= '0;
        end else begin
            unique case ({wr_busy, drain})
                2'b10:   level_q <= level_q + (depth+1)'(1);
                2'b01:   level_q <= level_q - (depth+1)'(1);
                default: level_q <= level_q;
            endcase
        end
    end

    assign bus.mem_a      = ptr_q;
    assign bus.mem_we     = we_q;
    assign bus.mem_di     = di_q;
    assign bus.level      = level_q;
    assign bus.frame_done = fd_q;

endmodule

// File: tb/tb_datamem_pack.sv
// Directed bench for datamem_pack: pairing, single-dword frames, fill to full,
// streaming with concurrent drain and pointer wrap, mid-frame reset, empty drain.
module tb_datamem_pack;

    localparam int DEPTH = 6;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;
    logic rd_req  = 1'b0;
    logic rd_auto = 1'b0;

    int total = 0;
    int bad   = 0;

    datamem_pack_if #(.depth(DEPTH)) bus ();

    datamem_pack #(.depth(DEPTH)) dut (
        .sys_clk (sys_clk),
        .sys_rst (sys_rst),
        .bus     (bus)
    );

    always #5 sys_clk = ~sys_clk;

    // Read side: manual pulses, or automatic draining that holds level near 32.
    assign bus.rd_done = rd_req | (rd_auto & (bus.level >= 7'd32));

    // Write-port monitor, sampled on the falling edge.
    logic [7:0]       obs_we[$];
    logic [DEPTH-1:0] obs_a[$];
    logic [63:0]      obs_di[$];
    logic             obs_fd[$];
    int drain_cnt   = 0;
    int overfill_cnt = 0;
    int stray_fd    = 0;

    always @(negedge sys_clk) begin
        if (!sys_rst) begin
            if (bus.mem_we != 8'h00) begin
                obs_we.push_back(bus.mem_we);
                obs_a.push_back(bus.mem_a);
                obs_di.push_back(bus.mem_di);
                obs_fd.push_back(bus.frame_done);
                if (bus.level >= 7'd64) overfill_cnt++;
            end else if (bus.frame_done) begin
                stray_fd++;
            end
            if (bus.rd_done && (bus.level != 7'd0)) drain_cnt++;
        end
    end

    // Inputs change 1 time unit after the rising edge, away from sampling.
    task automatic tick();
        @(posedge sys_clk);
        #1;
    endtask

    task automatic send(input logic [31:0] d, input logic last);
        int n;
        n = 0;
        tick();
        bus.in_valid = 1'b1;
        bus.in_data  = d;
        bus.in_last  = last;
        while (!bus.in_ready && n < 300) begin
            tick();
            n++;
        end
        if (!bus.in_ready) begin
            total++; bad++;
            $display("FAIL send_timeout: in_ready=%0b after %0d cycles, expected 1", bus.in_ready, n);
        end
    endtask

    task automatic idle(input int n);
        tick();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        repeat (n) tick();
    endtask

    task automatic do_reset();
        tick();
        sys_rst      = 1'b1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        rd_req       = 1'b0;
        rd_auto      = 1'b0;
        tick();
        sys_rst = 1'b0;
        tick();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        bus.in_data  = 32'h0;
        sys_rst = 1'b1;
        repeat (3) tick();
        total++; if (bus.mem_we !== 8'h00) begin bad++; $display("FAIL rst_we: got %h expected 00", bus.mem_we); end
        total++; if (bus.mem_di !== 64'h0) begin bad++; $display("FAIL rst_di: got %h expected 0", bus.mem_di); end
        total++; if (bus.mem_a !== 6'd0) begin bad++; $display("FAIL rst_a: got %0d expected 0", bus.mem_a); end
        total++; if (bus.frame_done !== 1'b0) begin bad++; $display("FAIL rst_fd: got %b expected 0", bus.frame_done); end
        total++; if (bus.level !== 7'd0) begin bad++; $display("FAIL rst_level: got %0d expected 0", bus.level); end
        sys_rst = 1'b0;
        tick();
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL rst_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_pair();
        int base;
        do_reset();
        base = obs_we.size();
        send(32'h11111111, 1'b0);
        send(32'h22222222, 1'b1);
        idle(3);
        total++;
        if (obs_we.size() - base != 1) begin
            bad++; $display("FAIL pair_count: got %0d writes expected 1", obs_we.size() - base);
        end else begin
            total++; if (obs_a[base] !== 6'd0) begin bad++; $display("FAIL pair_a: got %0d expected 0", obs_a[base]); end
            total++; if (obs_we[base] !== 8'hFF) begin bad++; $display("FAIL pair_we: got %h expected ff", obs_we[base]); end
            total++; if (obs_di[base] !== 64'h2222222211111111) begin bad++; $display("FAIL pair_di: got %h expected 2222222211111111", obs_di[base]); end
            total++; if (obs_fd[base] !== 1'b1) begin bad++; $display("FAIL pair_fd: got %b expected 1", obs_fd[base]); end
        end
        total++; if (bus.level !== 7'd1) begin bad++; $display("FAIL pair_level: got %0d expected 1", bus.level); end
    endtask

    task automatic test_single();
        int base;
        do_reset();
        base = obs_we.size();
        send(32'hDEADBEEF, 1'b1);
        send(32'h33333333, 1'b0);
        send(32'h44444444, 1'b1);
        idle(3);
        total++;
        if (obs_we.size() - base != 2) begin
            bad++; $display("FAIL single_count: got %0d writes expected 2", obs_we.size() - base);
        end else begin
            total++; if (obs_a[base] !== 6'd0) begin bad++; $display("FAIL single_a: got %0d expected 0", obs_a[base]); end
            total++; if (obs_we[base] !== 8'h0F) begin bad++; $display("FAIL single_we: got %h expected 0f", obs_we[base]); end
            total++; if (obs_di[base] !== 64'h00000000DEADBEEF) begin bad++; $display("FAIL single_di: got %h expected 00000000deadbeef", obs_di[base]); end
            total++; if (obs_fd[base] !== 1'b1) begin bad++; $display("FAIL single_fd: got %b expected 1", obs_fd[base]); end
            total++; if (obs_a[base+1] !== 6'd1) begin bad++; $display("FAIL after_single_a: got %0d expected 1", obs_a[base+1]); end
            total++; if (obs_di[base+1] !== 64'h4444444433333333) begin bad++; $display("FAIL after_single_di: got %h expected 4444444433333333", obs_di[base+1]); end
        end
        total++; if (bus.level !== 7'd2) begin bad++; $display("FAIL single_level: got %0d expected 2", bus.level); end
    endtask

    task automatic test_fill();
        int base;
        logic [63:0] exp_di;
        do_reset();
        base = obs_we.size();
        for (int i = 0; i < 128; i++) send(32'hC0000000 + 32'(i), (i == 127));
        idle(4);
        total++;
        if (obs_we.size() - base != 64) begin
            bad++; $display("FAIL fill_count: got %0d writes expected 64", obs_we.size() - base);
        end else begin
            for (int k = 0; k < 64; k++) begin
                exp_di = {32'hC0000000 + 32'(2*k+1), 32'hC0000000 + 32'(2*k)};
                total++; if (obs_a[base+k] !== 6'(k)) begin bad++; $display("FAIL fill_a[%0d]: got %0d expected %0d", k, obs_a[base+k], k); end
                total++; if (obs_di[base+k] !== exp_di) begin bad++; $display("FAIL fill_di[%0d]: got %h expected %h", k, obs_di[base+k], exp_di); end
            end
            total++; if (obs_fd[base+63] !== 1'b1) begin bad++; $display("FAIL fill_fd: got %b expected 1", obs_fd[base+63]); end
        end
        total++; if (bus.level !== 7'd64) begin bad++; $display("FAIL full_level: got %0d expected 64", bus.level); end
        total++; if (bus.in_ready !== 1'b0) begin bad++; $display("FAIL full_ready: got %b expected 0", bus.in_ready); end
        rd_req = 1'b1;
        tick();
        rd_req = 1'b0;
        tick();
        total++; if (bus.level !== 7'd63) begin bad++; $display("FAIL drain_level: got %0d expected 63", bus.level); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL drain_ready: got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_stream();
        int base, d0, drained;
        logic [63:0] exp_di;
        do_reset();
        base = obs_we.size();
        d0 = drain_cnt;
        rd_auto = 1'b1;
        for (int i = 0; i < 200; i++) send(32'hA0000000 + 32'(i), (i == 199));
        idle(3);
        rd_auto = 1'b0;
        repeat (3) tick();
        drained = drain_cnt - d0;
        total++;
        if (obs_we.size() - base != 100) begin
            bad++; $display("FAIL stream_count: got %0d writes expected 100", obs_we.size() - base);
        end else begin
            for (int k = 0; k < 100; k++) begin
                exp_di = {32'hA0000000 + 32'(2*k+1), 32'hA0000000 + 32'(2*k)};
                total++; if (obs_a[base+k] !== 6'(k % 64)) begin bad++; $display("FAIL stream_a[%0d]: got %0d expected %0d", k, obs_a[base+k], k % 64); end
                total++; if (obs_di[base+k] !== exp_di) begin bad++; $display("FAIL stream_di[%0d]: got %h expected %h", k, obs_di[base+k], exp_di); end
            end
        end
        total++; if (drained < 60) begin bad++; $display("FAIL stream_drains: got %0d expected at least 60", drained); end
        total++; if (int'(bus.level) != 100 - drained) begin bad++; $display("FAIL stream_level: got %0d expected %0d", bus.level, 100 - drained); end
        total++; if (overfill_cnt != 0) begin bad++; $display("FAIL overfill: got %0d writes at full expected 0", overfill_cnt); end
    endtask

    task automatic test_reset_midframe();
        int base;
        do_reset();
        base = obs_we.size();
        send(32'h55555555, 1'b0);
        tick();
        sys_rst      = 1'b1;
        bus.in_valid = 1'b0;
        tick();
        sys_rst = 1'b0;
        repeat (3) tick();
        total++; if (obs_we.size() != base) begin bad++; $display("FAIL midrst_write: got %0d writes expected 0", obs_we.size() - base); end
        total++; if (bus.level !== 7'd0) begin bad++; $display("FAIL midrst_level: got %0d expected 0", bus.level); end
        send(32'h66666666, 1'b0);
        send(32'h77777777, 1'b1);
        idle(3);
        total++;
        if (obs_we.size() - base != 1) begin
            bad++; $display("FAIL midrst_count: got %0d writes expected 1", obs_we.size() - base);
        end else begin
            total++; if (obs_a[base] !== 6'd0) begin bad++; $display("FAIL midrst_a: got %0d expected 0", obs_a[base]); end
            total++; if (obs_di[base] !== 64'h7777777766666666) begin bad++; $display("FAIL midrst_di: got %h expected 7777777766666666", obs_di[base]); end
        end
    endtask

    task automatic test_rd_empty();
        int base;
        do_reset();
        base = obs_we.size();
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b1;
        bus.in_data  = 32'hFFFFFFFF;
        rd_req = 1'b1;
        repeat (3) tick();
        rd_req = 1'b0;
        bus.in_data = 32'h12345678;
        repeat (3) tick();
        bus.in_last = 1'b0;
        total++; if (bus.level !== 7'd0) begin bad++; $display("FAIL empty_level: got %0d expected 0", bus.level); end
        total++; if (bus.in_ready !== 1'b1) begin bad++; $display("FAIL empty_ready: got %b expected 1", bus.in_ready); end
        total++; if (obs_we.size() != base) begin bad++; $display("FAIL empty_write: got %0d writes expected 0", obs_we.size() - base); end
        total++; if (stray_fd != 0) begin bad++; $display("FAIL stray_frame_done: got %0d expected 0", stray_fd); end
    endtask

    initial begin
        bus.in_data  = 32'h0;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
        test_reset();
        test_pair();
        test_single();
        test_fill();
        test_stream();
        test_reset_midframe();
        test_rd_empty();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
